// File: rtl/tl_cntr_w_left_timed.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tl_cntr_w_left_timed
//
// Traffic-light controller for a two-road intersection (roads A and B). Each
// road has a straight-green phase and a protected left-turn phase. A Moore FSM
// sequences the phases. A shared saturating phase counter enforces the
// minimum green, maximum green and fixed yellow durations.
//
// Optional feature: define TL_EMERGENCY_EN to add the emg input and an
// all-red state S8. While the feature is enabled, the state port is 4 bits wide.
//
// Ports:
//   clk    in   1  clock; all state updates happen on the rising edge
//   reset  in   1  synchronous active-high reset (forces S0, cnt=0)
//   Ta     in   1  road A straight traffic present
//   Tal    in   1  road A left-turn request
//   Tb     in   1  road B straight traffic present
//   Tbl    in   1  road B left-turn request
//   emg    in   1  emergency all-red request (TL_EMERGENCY_EN only)
//   La     out  2  road A lamp: 00 green, 01 yellow, 10 left arrow, 11 red
//   Lb     out  2  road B lamp, same encoding
//   state  out  3  current FSM state for debug (4 bits with TL_EMERGENCY_EN)
// -----------------------------------------------------------------------------
module tl_cntr_w_left_timed #(
    parameter int MIN_GREEN     = 4,
    parameter int MAX_GREEN     = 16,
    parameter int YELLOW_CYCLES = 2,
    parameter int CNT_W         = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Ta,
    input  logic       Tal,
    input  logic       Tb,
    input  logic       Tbl,
`ifdef TL_EMERGENCY_EN
    input  logic       emg,
`endif
    output logic [1:0] La,
    output logic [1:0] Lb,
`ifdef TL_EMERGENCY_EN
    output logic [3:0] state
`else
    output logic [2:0] state
`endif
);

`ifdef TL_EMERGENCY_EN
    localparam int SW = 4;
`else
    localparam int SW = 3;
`endif

    typedef enum logic [SW-1:0] {
        S0_A_GREEN = SW'(0),
        S1_A_YEL1  = SW'(1),
        S2_A_LEFT  = SW'(2),
        S3_A_YEL2  = SW'(3),
        S4_B_GREEN = SW'(4),
        S5_B_YEL1  = SW'(5),
        S6_B_LEFT  = SW'(6),
        S7_B_YEL2  = SW'(7)
`ifdef TL_EMERGENCY_EN
        ,
        S8_ALL_RED = SW'(8)
`endif
    } state_t;

    localparam logic [1:0] LAMP_GREEN = 2'b00;
    localparam logic [1:0] LAMP_YEL   = 2'b01;
    localparam logic [1:0] LAMP_LEFT  = 2'b10;
    localparam logic [1:0] LAMP_RED   = 2'b11;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       la_reg;
    logic [1:0]       la_next;
    logic [1:0]       lb_reg;
    logic [1:0]       lb_next;

    logic at_min;
    logic at_max;
    logic at_yel;
    logic cnt_full;

    assign at_min   = (cnt_reg >= CNT_W'(MIN_GREEN - 1));
    assign at_max   = (cnt_reg == CNT_W'(MAX_GREEN - 1));
    assign at_yel   = (cnt_reg == CNT_W'(YELLOW_CYCLES - 1));
    assign cnt_full = (cnt_reg == {CNT_W{1'b1}});

    // A green or left phase ends once the minimum has elapsed and its sensor
    // is idle, or unconditionally at the maximum. Sensors are sampled only at
    // the decision point; nothing is latched.
    function automatic logic phase_done(input logic sensor, input logic min_ok,
                                        input logic max_hit);
        return (min_ok && !sensor) || max_hit;
    endfunction

    // Next-state decode
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            S0_A_GREEN: if (phase_done(Ta, at_min, at_max))  state_next = S1_A_YEL1;
            S1_A_YEL1:  if (at_yel) state_next = Tal ? S2_A_LEFT : S4_B_GREEN;
            S2_A_LEFT:  if (phase_done(Tal, at_min, at_max)) state_next = S3_A_YEL2;
            S3_A_YEL2:  if (at_yel) state_next = S4_B_GREEN;
            S4_B_GREEN: if (phase_done(Tb, at_min, at_max))  state_next = S5_B_YEL1;
            S5_B_YEL1:  if (at_yel) state_next = Tbl ? S6_B_LEFT : S0_A_GREEN;
            S6_B_LEFT:  if (phase_done(Tbl, at_min, at_max)) state_next = S7_B_YEL2;
            S7_B_YEL2:  if (at_yel) state_next = S0_A_GREEN;
`ifdef TL_EMERGENCY_EN
            // Holding while emg=1 is handled by the override in the register
            // block, so reaching this decode means emg has dropped.
            S8_ALL_RED: state_next = S0_A_GREEN;
`endif
            default:    state_next = S0_A_GREEN;
        endcase
    end

    // The phase counter restarts on every state change. Otherwise it
    // saturates rather than wraps, so a stuck phase can never look freshly
    // entered.
    always_comb begin
        if (state_next != state_reg) begin
            cnt_next = '0;
        end else if (cnt_full) begin
            cnt_next = cnt_reg;
        end else begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    // Lamps are decoded from the next state and registered together with it.
    // The lamp registers therefore always match the state register, and
    // sensors cannot reach the lamps combinationally.
    always_comb begin
        la_next = LAMP_RED;
        lb_next = LAMP_RED;
        unique case (state_next)
            S0_A_GREEN: la_next = LAMP_GREEN;
            S1_A_YEL1:  la_next = LAMP_YEL;
            S2_A_LEFT:  la_next = LAMP_LEFT;
            S3_A_YEL2:  la_next = LAMP_YEL;
            S4_B_GREEN: lb_next = LAMP_GREEN;
            S5_B_YEL1:  lb_next = LAMP_YEL;
            S6_B_LEFT:  lb_next = LAMP_LEFT;
            S7_B_YEL2:  lb_next = LAMP_YEL;
            default: begin
                la_next = LAMP_RED;
                lb_next = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S0_A_GREEN;
            cnt_reg   <= '0;
            la_reg    <= LAMP_GREEN;
            lb_reg    <= LAMP_RED;
`ifdef TL_EMERGENCY_EN
        end else if (emg) begin
            state_reg <= S8_ALL_RED;
            cnt_reg   <= '0;
            la_reg    <= LAMP_RED;
            lb_reg    <= LAMP_RED;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            la_reg    <= la_next;
            lb_reg    <= lb_next;
        end
    end

    assign La    = la_reg;
    assign Lb    = lb_reg;
    assign state = state_reg;

endmodule
